mem_port_arbiter: RTL and testbench

- Shares one single-port Mem primitive between NUM_REQ fabric requesters.
- Uses per-requester valid/ready request channels and round-robin grant.
- Pipelined: accepts one access per cycle, holds the Mem port with registered drive, and routes each read response back to its issuer.
- Sits between requester logic (ALU/reg_unit datapaths, IO bridges) and the Mem blackbox (addr0, write_data, write_en, read_data).

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Holds data/address width defaults, the tag-width helper and the in-flight entry type.
package mem_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;
    localparam int TAG_W_MAX  = 3;

    // Index width for NUM_REQ requesters; a single requester still needs one bit.
    function automatic int tag_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    typedef struct packed {
        logic                 valid;
        logic                 is_read;
        logic [TAG_W_MAX-1:0] tag;
    } inflight_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority picker: first set request at or above ptr, with wrap.
// Produces a one-hot grant, the winner index and an any-request flag.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = tag_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [TAG_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [TAG_W-1:0]   winner,
    output logic               any_valid
);

    function automatic int wrap_idx(input int p, input int o);
        return (p + o) % NUM_REQ;
    endfunction

    logic found_s;

    // Scan requesters starting at ptr and keep the first one found.
    always_comb begin
        grant   = '0;
        winner  = '0;
        found_s = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!found_s && req[wrap_idx(int'(ptr), off)]) begin
                found_s                            = 1'b1;
                grant[wrap_idx(int'(ptr), off)]    = 1'b1;
                winner                             = TAG_W'(wrap_idx(int'(ptr), off));
            end else begin
                found_s = found_s;
            end
        end
    end

    assign any_valid = found_s;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port Mem between NUM_REQ requesters with round-robin grant and
// a 2-cycle read return path. Optional burst lock is enabled by defining MEM_ARB_LOCK_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic [ADDR_W-1:0]         mem_addr0,
    output logic [DATA_W-1:0]         mem_write_data,
    output logic                      mem_write_en,
    input  logic [DATA_W-1:0]         mem_read_data
);

    localparam int TAG_W = tag_width(NUM_REQ);

    logic [TAG_W-1:0]   ptr_r;
    logic [TAG_W-1:0]   next_ptr_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [TAG_W-1:0]   winner_s;
    logic               any_s;
    logic               hs_s;
    logic               lock_s;

    logic [ADDR_W-1:0]  mem_addr_r;
    logic [DATA_W-1:0]  mem_wdata_r;
    logic               mem_we_r;
    inflight_t          pipe0_r;
    inflight_t          pipe1_r;
    logic [NUM_REQ-1:0] resp_valid_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .winner    (winner_s),
        .any_valid (any_s)
    );

    assign hs_s = any_s & ~reset;

`ifdef MEM_ARB_LOCK_EN
    assign lock_s = req_lock[winner_s];
`else
    assign lock_s = 1'b0;
`endif

    // Grant is suppressed while reset is held so nothing is accepted during reset.
    always_comb begin
        if (reset) begin
            req_ready = '0;
        end else begin
            req_ready = grant_s;
        end
    end

    // A locked winner keeps the pointer on itself; otherwise it moves past the winner.
    always_comb begin
        if (lock_s) begin
            next_ptr_s = winner_s;
        end else if (winner_s == TAG_W'(NUM_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = winner_s + TAG_W'(1);
        end
    end

    // Round-robin pointer advances only on a handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (hs_s) begin
            ptr_r <= next_ptr_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Issue register drives the Mem port; address/data hold when idle, write enable does not.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_we_r    <= 1'b0;
        end else if (hs_s) begin
            mem_addr_r  <= req_addr[winner_s*ADDR_W +: ADDR_W];
            mem_wdata_r <= req_wdata[winner_s*DATA_W +: DATA_W];
            mem_we_r    <= req_we[winner_s];
        end else begin
            mem_addr_r  <= mem_addr_r;
            mem_wdata_r <= mem_wdata_r;
            mem_we_r    <= 1'b0;
        end
    end

    // Owner tag and read flag follow the access through issue and Mem read stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe0_r <= '0;
            pipe1_r <= '0;
        end else begin
            if (hs_s) begin
                pipe0_r.valid   <= 1'b1;
                pipe0_r.is_read <= ~req_we[winner_s];
                pipe0_r.tag     <= TAG_W_MAX'(winner_s);
            end else begin
                pipe0_r <= '0;
            end
            pipe1_r <= pipe0_r;
        end
    end

    // Reset also gates the strobe immediately so an in-flight response is never seen.
    always_comb begin
        resp_valid_s = '0;
        if (!reset && pipe1_r.valid && pipe1_r.is_read) begin
            resp_valid_s[pipe1_r.tag[TAG_W-1:0]] = 1'b1;
        end else begin
            resp_valid_s = '0;
        end
    end

    // A write still sitting in the issue register is cancelled when reset arrives.
    always_comb begin
        if (reset) begin
            mem_write_en = 1'b0;
        end else begin
            mem_write_en = mem_we_r;
        end
    end

    assign mem_addr0      = mem_addr_r;
    assign mem_write_data = mem_wdata_r;
    assign resp_valid     = resp_valid_s;
    assign resp_rdata     = mem_read_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a registered-read Mem model.
// Define MEM_ARB_LOCK_EN on both RTL and bench to exercise burst lock.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
`ifdef MEM_ARB_LOCK_EN
    logic [N-1:0]    req_lock;
`endif
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_rdata;
    logic [AW-1:0]   mem_addr0;
    logic [DW-1:0]   mem_write_data;
    logic            mem_write_en;
    logic [DW-1:0]   mem_read_data;

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
`ifdef MEM_ARB_LOCK_EN
        .req_lock       (req_lock),
`endif
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .mem_addr0      (mem_addr0),
        .mem_write_data (mem_write_data),
        .mem_write_en   (mem_write_en),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Mem model: word i preloaded with 0xA0000000+i, registered read-first port.
    logic [DW-1:0] mem [64];
    logic          mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + i;
            mem_init_done <= 1'b1;
            mem_read_data <= 32'h0;
        end else begin
            if (mem_write_en) mem[mem_addr0[7:2]] <= mem_write_data;
            mem_read_data <= mem[mem_addr0[7:2]];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int i, input logic [31:0] a);
        req_addr[i*AW +: AW] = a;
        req_we[i]            = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_we    = 4'b0000;
        req_addr  = '0;
        req_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
        req_lock  = 4'b0000;
`endif
        // reset held 3 cycles with every requester valid
        for (int c = 0; c < 3; c++) begin
            settle();
            check("rst_ready", req_ready, 4'b0000);
            check("rst_we", mem_write_en, 1'b0);
            check("rst_resp", resp_valid, 4'b0000);
            next_cycle();
        end
        reset = 1'b0;

        // A: req0 writes 0x10, req2 reads 0x10 pending; ptr=0 picks req0
        req_valid = 4'b0101;
        req_we[0] = 1'b1;
        req_addr[0*AW +: AW] = 32'h10;
        req_wdata[0*DW +: DW] = 32'hDEAD_BEEF;
        set_rd(2, 32'h10);
        settle();
        check("wr_ready0", req_ready, 4'b0001);
        next_cycle();
        // B: write issued, req2 granted
        req_valid = 4'b0100;
        settle();
        check("rd_ready2", req_ready, 4'b0100);
        check("wr_en", mem_write_en, 1'b1);
        check("wr_addr", mem_addr0, 32'h10);
        check("wr_data", mem_write_data, 32'hDEAD_BEEF);
        next_cycle();
        // C: read issued
        req_valid = 4'b0000;
        settle();
        check("wr_pulse_end", mem_write_en, 1'b0);
        check("rd_addr", mem_addr0, 32'h10);
        check("rd_resp_early", resp_valid, 4'b0000);
        next_cycle();
        // D: response 2 cycles after read handshake
        settle();
        check("rd_resp", resp_valid, 4'b0100);
        check("rd_data", resp_rdata, 32'hDEAD_BEEF);
        next_cycle();

        // E: ptr=3, only req1 valid -> wrap to req1, ptr becomes 2
        req_valid = 4'b0010;
        set_rd(1, 32'h8);
        settle();
        check("wrap_ready1", req_ready, 4'b0010);
        next_cycle();
        // F: req0 and req2 valid; ptr=2 must pick req2
        req_valid = 4'b0101;
        set_rd(0, 32'h0);
        set_rd(2, 32'hC);
        settle();
        check("ptr2_ready", req_ready, 4'b0100);
        check("wrap_addr", mem_addr0, 32'h8);
        next_cycle();
        // G: req0 withdraws before grant
        req_valid = 4'b0000;
        settle();
        check("wrap_resp", resp_valid, 4'b0010);
        check("wrap_data", resp_rdata, 32'hA000_0002);
        check("skip_addr", mem_addr0, 32'hC);
        next_cycle();
        // H: response for req2; new read by req0 (ptr=3 wraps to 0)
        req_valid = 4'b0001;
        set_rd(0, 32'h0);
        settle();
        check("skip_resp", resp_valid, 4'b0100);
        check("skip_data", resp_rdata, 32'hA000_0003);
        check("mid_ready0", req_ready, 4'b0001);
        next_cycle();
        // I: second read by req1
        req_valid = 4'b0010;
        set_rd(1, 32'h4);
        settle();
        check("mid_ready1", req_ready, 4'b0010);
        next_cycle();
        // J: reset while both reads are in flight
        reset     = 1'b1;
        req_valid = 4'b0000;
        settle();
        check("mid_rst_resp0", resp_valid, 4'b0000);
        check("mid_rst_ready", req_ready, 4'b0000);
        next_cycle();
        // K: after release nothing returns
        reset = 1'b0;
        settle();
        check("mid_rst_resp1", resp_valid, 4'b0000);
        check("mid_rst_we", mem_write_en, 1'b0);
        next_cycle();

        // fairness: all valid reading 0x0/0x4/0x8/0xC, ptr reset to 0
        for (int i = 0; i < N; i++) set_rd(i, 32'(i * 4));
        for (int k = 0; k < 10; k++) begin
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            settle();
            if (k < 8) check($sformatf("fair_ready_%0d", k), req_ready, 4'b0001 << (k % 4));
            if (k >= 2) begin
                check($sformatf("fair_resp_%0d", k), resp_valid, 4'b0001 << ((k - 2) % 4));
                check($sformatf("fair_data_%0d", k), resp_rdata, 32'hA000_0000 + 32'((k - 2) % 4));
            end
            next_cycle();
        end

        // single requester granted every cycle
        req_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            settle();
            check($sformatf("single_ready_%0d", k), req_ready, 4'b1000);
            next_cycle();
        end
        req_valid = 4'b0000;
        settle();
        check("single_resp", resp_valid, 4'b1000);
        check("single_data", resp_rdata, 32'hA000_0003);
        next_cycle();

`ifdef MEM_ARB_LOCK_EN
        // move ptr to 1, then req1 locks for two handshakes and releases on the third
        req_valid = 4'b0001;
        settle();
        check("lock_pre", req_ready, 4'b0001);
        next_cycle();
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            req_lock = (k < 2) ? 4'b0010 : 4'b0000;
            settle();
            check($sformatf("lock_ready_%0d", k), req_ready, 4'b0010);
            next_cycle();
        end
        req_lock = 4'b0000;
        settle();
        check("lock_release", req_ready, 4'b0100);
        next_cycle();
        req_valid = 4'b0000;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
